// File: rtl/i2c_target_regs.sv
// I2C target with a 7-bit device address that bridges bus transfers onto a byte-wide
// register port through an auto-incrementing 8-bit pointer. It never stretches SCL.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  typedef enum logic [3:0] {
    IDLE, DEVADR, DEVACK, REGADR, REGACK, WRDAT, WRACK, RDDAT, RDACK, IGNORE
  } state_t;

  state_t state, state_next;

  logic [1:0]          scl_sync, sda_sync;
  logic [1:0]          raw, filt;
  logic [1:0][FCW-1:0] fcnt;
  logic                scl_f, sda_f, scl_q, sda_q;
  logic                scl_rise, scl_fall, start, stop;

  logic [6:0] shift;
  logic [7:0] rx_byte;
  logic [2:0] bit_cnt;
  logic       last_bit;
  logic [7:0] tx;
  logic [7:0] ptr;
  logic       rw;
  logic       rd_d;

  logic addr_hit, ptr_load, wr_req, rd_req, ptr_inc;

  // Two-flop synchronisers; the bus idles high, so they reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

  assign raw = {scl_sync[1], sda_sync[1]};

  // A filtered line only follows the synchronised one after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 2'b11;
      fcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_f    = filt[1];
  assign sda_f    = filt[0];
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte  = {shift, sda_f};
  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // START/STOP are tested before any SCL edge so they always win.
  always_comb begin
    state_next = state;
    addr_hit   = 1'b0;
    ptr_load   = 1'b0;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    ptr_inc    = 1'b0;
    if (start) begin
      state_next = DEVADR;
    end else if (stop) begin
      state_next = IDLE;
    end else if (scl_rise) begin
      case (state)
        DEVADR: if (last_bit) begin
          if (rx_byte[7:1] == DEV_ADDR) begin
            state_next = DEVACK;
            addr_hit   = 1'b1;
          end else begin
            state_next = IGNORE;
          end
        end
        DEVACK: begin
          if (rw) begin
            state_next = RDDAT;
            rd_req     = 1'b1;
          end else begin
            state_next = REGADR;
          end
        end
        REGADR: if (last_bit) begin
          state_next = REGACK;
          ptr_load   = 1'b1;
        end
        REGACK: state_next = WRDAT;
        WRDAT: if (last_bit) begin
          state_next = WRACK;
          wr_req     = 1'b1;
          ptr_inc    = 1'b1;
        end
        WRACK: state_next = WRDAT;
        RDDAT: if (last_bit) state_next = RDACK;
        RDACK: begin
          ptr_inc = 1'b1;
          if (!sda_f) begin
            state_next = RDDAT;
            rd_req     = 1'b1;
          end else begin
            state_next = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  // On a read ACK the request already targets the incremented pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      shift     <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      rd_d      <= 1'b0;
      busy      <= 1'b0;
      sda_oe    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      scl_q  <= scl_f;
      sda_q  <= sda_f;
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      rd_d   <= reg_rd;

      if (start || stop) begin
        bit_cnt <= '0;
      end else if (scl_rise) begin
        shift <= rx_byte[6:0];
        if (state inside {DEVADR, REGADR, WRDAT, RDDAT}) bit_cnt <= bit_cnt + 3'd1;
      end

      if (addr_hit) begin
        busy <= 1'b1;
        rw   <= rx_byte[0];
      end
      if (stop) busy <= 1'b0;

      if (ptr_load)     ptr <= rx_byte;
      else if (ptr_inc) ptr <= ptr + 8'd1;

      if (wr_req) begin
        reg_wr    <= 1'b1;
        reg_addr  <= ptr;
        reg_wdata <= rx_byte;
      end
      if (rd_req) begin
        reg_rd   <= 1'b1;
        reg_addr <= (state == RDACK) ? ptr + 8'd1 : ptr;
      end

      // The responder's data is sampled on the cycle after the read strobe.
      if (rd_d) begin
        tx <= reg_rdata;
      end else if (scl_fall && state == RDDAT) begin
        tx <= {tx[6:0], 1'b0};
      end

      if (start || state_next == IDLE || state_next == IGNORE) begin
        sda_oe <= 1'b0;
      end else if (scl_fall) begin
        case (state)
          DEVACK, REGACK, WRACK: sda_oe <= 1'b1;
          RDDAT:                 sda_oe <= ~tx[7];
          default:               sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench acting as I2C controller plus a small register-file responder; expectations
// come from a byte-array model of the register space and the pointer rules.
module tb_i2c_target_regs;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, reg_wr, reg_rd, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] rdata = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regs #(.DEV_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (rdata),
    .busy      (busy)
  );

  // Responder: unwritten locations read as addr^0x5A, data one cycle after reg_rd.
  logic [7:0]   mem [256];
  logic [255:0] written = '0;
  always @(posedge clk) begin
    if (reg_wr) begin
      mem[reg_addr]     <= reg_wdata;
      written[reg_addr] <= 1'b1;
    end
    if (reg_rd) rdata <= written[reg_addr] ? mem[reg_addr] : (reg_addr ^ 8'h5A);
  end

  // Strobe and activity log.
  logic [7:0] wr_a_log [256];
  logic [7:0] wr_d_log [256];
  logic [7:0] rd_a_log [256];
  int wr_n = 0, rd_n = 0, both_cnt = 0, long_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_a_log[wr_n[7:0]] <= reg_addr;
      wr_d_log[wr_n[7:0]] <= reg_wdata;
      wr_n <= wr_n + 1;
    end
    if (reg_rd) begin
      rd_a_log[rd_n[7:0]] <= reg_addr;
      rd_n <= rd_n + 1;
    end
    if (reg_wr && reg_rd) both_cnt <= both_cnt + 1;
    if ((reg_wr && wr_prev) || (reg_rd && rd_prev)) long_cnt <= long_cnt + 1;
    wr_prev <= reg_wr;
    rd_prev <= reg_rd;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Reference register space.
  logic [7:0] model_mem [256];

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    sda_m = 1'b0; wq(2 * Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    sda_m = 1'b1; wq(2 * Q);
  endtask

  task automatic bus_bit(input logic b, input bit glitch, output logic s);
    sda_m = b; wq(Q);
    scl_m = 1'b1; wq(5);
    if (glitch) begin
      scl_m = 1'b0; wq(1);
      scl_m = 1'b1; wq(2);
      sda_m = ~b;   wq(1);
      sda_m = b;
    end else begin
      wq(4);
    end
    s = sda_line;
    wq(11);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], glitch, s);
    bus_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    bus_bit(nack, 1'b0, s);
  endtask

  task automatic xfer_write(input logic [7:0] ptr, input logic [7:0] d[4], input int n,
                            input bit glitch, output bit all_ack);
    logic a;
    all_ack = 1'b1;
    bus_start();
    write_byte(8'hA0, 1'b0, a); all_ack &= a;
    write_byte(ptr, 1'b0, a);   all_ack &= a;
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], glitch, a); all_ack &= a;
    end
    bus_stop();
  endtask

  task automatic xfer_read(input logic [7:0] ptr, input int n, output logic [7:0] d[4],
                           output bit all_ack);
    logic a;
    all_ack = 1'b1;
    d = '{default: 8'h00};
    bus_start();
    write_byte(8'hA0, 1'b0, a); all_ack &= a;
    write_byte(ptr, 1'b0, a);   all_ack &= a;
    bus_start();
    write_byte(8'hA1, 1'b0, a); all_ack &= a;
    for (int i = 0; i < n; i++) read_byte(i == n - 1, d[i]);
    bus_stop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wq(5);
    n_checks++;
    if ({sda_oe, busy, reg_wr, reg_rd} !== 4'b0000)
      $display("FAIL reset_ctrl got %b required 0000", {sda_oe, busy, reg_wr, reg_rd});
    else n_pass++;
    n_checks++;
    if ({reg_addr, reg_wdata} !== 16'h0000)
      $display("FAIL reset_bus got %h required 0000", {reg_addr, reg_wdata});
    else n_pass++;
    rst_n = 1'b1;
    wq(5);
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    logic [7:0] ed [2];
    int w0;
    ed[0] = 8'hAB; ed[1] = 8'hCD;
    w0 = wr_n;
    bus_start();
    write_byte(8'hA0, 1'b0, a0);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL write_busy_on got %b required 1", busy);
    else n_pass++;
    write_byte(8'h10, 1'b0, a1);
    write_byte(8'hAB, 1'b0, a2);
    write_byte(8'hCD, 1'b0, a3);
    bus_stop();
    model_mem[8'h10] = 8'hAB;
    model_mem[8'h11] = 8'hCD;
    n_checks++;
    if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL write_acks got %b required 1111", {a0, a1, a2, a3});
    else n_pass++;
    n_checks++;
    if (wr_n - w0 !== 2) $display("FAIL write_count got %0d required 2", wr_n - w0);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({wr_a_log[8'(w0 + i)], wr_d_log[8'(w0 + i)]} !== {8'(8'h10 + i), ed[i]})
        $display("FAIL write_strobe%0d got %h required %h", i,
                 {wr_a_log[8'(w0 + i)], wr_d_log[8'(w0 + i)]}, {8'(8'h10 + i), ed[i]});
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL write_busy_off got %b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_random_read();
    logic [7:0] d [4];
    bit ok;
    int r0;
    r0 = rd_n;
    xfer_read(8'h20, 3, d, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL rread_acks got %b required 1", ok);
    else n_pass++;
    n_checks++;
    if (rd_n - r0 !== 3) $display("FAIL rread_count got %0d required 3", rd_n - r0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_a_log[8'(r0 + i)] !== 8'(8'h20 + i))
        $display("FAIL rread_addr%0d got %h required %h", i, rd_a_log[8'(r0 + i)], 8'(8'h20 + i));
      else n_pass++;
      n_checks++;
      if (d[i] !== model_mem[8'(8'h20 + i)])
        $display("FAIL rread_data%0d got %h required %h", i, d[i], model_mem[8'(8'h20 + i)]);
      else n_pass++;
    end
  endtask

  task automatic test_mismatch();
    int w0, r0, o0, b0;
    logic a;
    w0 = wr_n; r0 = rd_n; o0 = oe_cnt; b0 = busy_cnt;
    bus_start();
    write_byte(8'hA2, 1'b0, a);
    n_checks++;
    if (a !== 1'b0) $display("FAIL mismatch_ack got %b required 0", a);
    else n_pass++;
    write_byte(8'h05, 1'b0, a);
    write_byte(8'h3C, 1'b0, a);
    bus_stop();
    n_checks++;
    if ({wr_n - w0, rd_n - r0, oe_cnt - o0, busy_cnt - b0} !== 128'd0)
      $display("FAIL mismatch_quiet got wr=%0d rd=%0d oe=%0d busy=%0d required all 0",
               wr_n - w0, rd_n - r0, oe_cnt - o0, busy_cnt - b0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] d [4];
    bit ok;
    int w0;
    d = '{8'h11, 8'h22, 8'h00, 8'h00};
    w0 = wr_n;
    xfer_write(8'hFF, d, 2, 1'b0, ok);
    model_mem[8'hFF] = 8'h11;
    model_mem[8'h00] = 8'h22;
    n_checks++;
    if (ok !== 1'b1 || wr_n - w0 !== 2) $display("FAIL wrap_acks_count got ack=%b n=%0d required 1/2", ok, wr_n - w0);
    else n_pass++;
    n_checks++;
    if ({wr_a_log[8'(w0)], wr_a_log[8'(w0 + 1)]} !== 16'hFF00)
      $display("FAIL wrap_addr got %h required ff00", {wr_a_log[8'(w0)], wr_a_log[8'(w0 + 1)]});
    else n_pass++;
  endtask

  task automatic test_stop_mid();
    logic a, s;
    logic [7:0] d [4];
    bit ok;
    int w0;
    w0 = wr_n;
    bus_start();
    write_byte(8'hA0, 1'b0, a);
    write_byte(8'h40, 1'b0, a);
    for (int i = 0; i < 4; i++) bus_bit(i[0], 1'b0, s);
    bus_stop();
    n_checks++;
    if (wr_n - w0 !== 0 || busy !== 1'b0)
      $display("FAIL stopmid_nowrite got n=%0d busy=%b required 0/0", wr_n - w0, busy);
    else n_pass++;
    d = '{8'h99, 8'h00, 8'h00, 8'h00};
    xfer_write(8'h41, d, 1, 1'b0, ok);
    model_mem[8'h41] = 8'h99;
    n_checks++;
    if (ok !== 1'b1 || wr_n - w0 !== 1 || {wr_a_log[8'(w0)], wr_d_log[8'(w0)]} !== 16'h4199)
      $display("FAIL stopmid_next got ack=%b n=%0d strobe=%h required 1/1/4199",
               ok, wr_n - w0, {wr_a_log[8'(w0)], wr_d_log[8'(w0)]});
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [7:0] d [4];
    logic [7:0] q [4];
    bit ok;
    int w0;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    w0 = wr_n;
    xfer_write(8'h60, d, 4, 1'b1, ok);
    for (int i = 0; i < 4; i++) model_mem[8'(8'h60 + i)] = d[i];
    n_checks++;
    if (ok !== 1'b1 || wr_n - w0 !== 4) $display("FAIL glitch_write got ack=%b n=%0d required 1/4", ok, wr_n - w0);
    else n_pass++;
    xfer_read(8'h60, 4, q, ok);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (q[i] !== model_mem[8'(8'h60 + i)])
        $display("FAIL glitch_data%0d got %h required %h", i, q[i], model_mem[8'(8'h60 + i)]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] d [4];
    logic [7:0] q [4];
    logic [7:0] ptr;
    bit ok;
    int n, w0, r0, bad;
    for (int it = 0; it < 6; it++) begin
      ptr = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      w0 = wr_n;
      xfer_write(ptr, d, n, 1'b0, ok);
      for (int i = 0; i < n; i++) model_mem[8'(ptr + i)] = d[i];
      bad = 0;
      for (int i = 0; i < n; i++)
        if ({wr_a_log[8'(w0 + i)], wr_d_log[8'(w0 + i)]} !== {8'(ptr + i), d[i]}) bad++;
      n_checks++;
      if (ok !== 1'b1 || wr_n - w0 !== n || bad != 0)
        $display("FAIL rand_write%0d got ack=%b n=%0d bad=%0d required 1/%0d/0", it, ok, wr_n - w0, bad, n);
      else n_pass++;
      ptr = ptr + 8'($urandom_range(0, 2));
      r0 = rd_n;
      xfer_read(ptr, n, q, ok);
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (rd_a_log[8'(r0 + i)] !== 8'(ptr + i)) bad++;
        if (q[i] !== model_mem[8'(ptr + i)]) bad++;
      end
      n_checks++;
      if (ok !== 1'b1 || rd_n - r0 !== n || bad != 0)
        $display("FAIL rand_read%0d got ack=%b n=%0d bad=%0d required 1/%0d/0", it, ok, rd_n - r0, bad, n);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d [4];
    logic a;
    bit ok;
    int r0;
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    xfer_write(8'h30, d, 1, 1'b0, ok);
    model_mem[8'h30] = 8'h00;
    bus_start();
    write_byte(8'hA0, 1'b0, a);
    write_byte(8'h30, 1'b0, a);
    bus_start();
    write_byte(8'hA1, 1'b0, a);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(5);
    n_checks++;
    if (sda_oe !== 1'b1) $display("FAIL rstmid_driving got %b required 1", sda_oe);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sda_oe, busy, reg_addr} !== 10'd0)
      $display("FAIL rstmid_immediate got oe=%b busy=%b addr=%h required 0/0/00", sda_oe, busy, reg_addr);
    else n_pass++;
    wq(4);
    rst_n = 1'b1;
    wq(4);
    scl_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    r0 = rd_n;
    bus_start();
    write_byte(8'hA1, 1'b0, a);
    read_byte(1'b1, d[0]);
    bus_stop();
    n_checks++;
    if (a !== 1'b1 || rd_n - r0 !== 1 || rd_a_log[8'(r0)] !== 8'h00 || d[0] !== model_mem[8'h00])
      $display("FAIL rstmid_ptr0 got ack=%b n=%0d addr=%h data=%h required 1/1/00/%h",
               a, rd_n - r0, rd_a_log[8'(r0)], d[0], model_mem[8'h00]);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_write();
    test_random_read();
    test_mismatch();
    test_wrap();
    test_stop_mid();
    test_glitch();
    test_random();
    test_reset_mid_read();
    n_checks++;
    if (both_cnt !== 0 || long_cnt !== 0)
      $display("FAIL strobe_shape got both=%0d long=%0d required 0/0", both_cnt, long_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
